// File: rtl/synth_pkg.sv
// synth_pkg: sizing defaults and the priority helper shared by the voice path
package synth_pkg;
    localparam int DEF_NUM_KEYS = 8;
    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_KEY_W = 3;

    // index of the lowest set bit, 0 when nothing is set (callers gate on |v)
    function automatic int lowest_bit(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--)
            if (v[i]) idx = i;
        return idx;
    endfunction
endpackage

// File: rtl/voice_allocator_key_edge.sv
// key_edge: 2-FF synchronizer plus previous-sample register for one active-low key
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press,
    output logic rel
);
    logic s1, s2, prev;

    // synchronize the raw key and keep the previous synchronized sample; reset reads as released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
            prev <= s2;
        end
    end

    assign press = prev & ~s2;
    assign rel = ~prev & s2;
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: shares tone-generator voices between keys, stealing round-robin when full
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int KEY_W = DEF_KEY_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_KEYS-1:0]         key_n,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic [NUM_VOICES-1:0]       note_on,
    output logic [NUM_VOICES-1:0]       note_off,
    output logic                        steal,
    output logic                        busy
);
    localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;

    logic [NUM_KEYS-1:0]   press, rel, pend, pend_eff, pend_next;
    logic [NUM_VOICES-1:0] free, rel_hit;
    logic [VW-1:0]         steal_ptr, target;
    logic [KEY_W-1:0]      akey;
    logic                  alloc, any_free;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_edge u_edge (
            .clk(clk),
            .rst(rst),
            .key_n(key_n[k]),
            .press(press[k]),
            .rel(rel[k])
        );
    end

    // choose the key to serve and its voice; a key releasing while still queued is dropped, not served
    always_comb begin
        pend_eff = pend & ~rel;
        free = ~voice_active;
        alloc = |pend_eff;
        any_free = |free;
        akey = KEY_W'(lowest_bit(32'(pend_eff)));
        target = any_free ? VW'(lowest_bit(32'(free))) : steal_ptr;
        pend_next = (pend | press) & ~rel;
        if (alloc) pend_next[akey] = 1'b0;
        rel_hit = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            rel_hit[v] = voice_active[v] & rel[voice_key[v*KEY_W +: KEY_W]];
    end

    // voice table and event pulses; a new assignment overrides a same-cycle release of that voice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            voice_active <= '0;
            voice_key <= '0;
            note_on <= '0;
            note_off <= '0;
            steal <= 1'b0;
            busy <= 1'b0;
            pend <= '0;
            steal_ptr <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (alloc && target == VW'(v)) begin
                    voice_active[v] <= 1'b1;
                    voice_key[v*KEY_W +: KEY_W] <= akey;
                    note_on[v] <= 1'b1;
                    note_off[v] <= 1'b0;
                end else begin
                    note_on[v] <= 1'b0;
                    note_off[v] <= rel_hit[v];
                    if (rel_hit[v]) voice_active[v] <= 1'b0;
                end
            end
            steal <= alloc & ~any_free;
            if (alloc & ~any_free)
                steal_ptr <= steal_ptr == VW'(NUM_VOICES - 1) ? '0 : steal_ptr + 1'b1;
            pend <= pend_next;
            busy <= |pend_next;
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed and random key traffic checked against a behavioural voice model
module tb_voice_allocator;
    localparam int NK = 8;
    localparam int NV = 4;
    localparam int KW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NK-1:0] key_n = '1;
    logic [NV-1:0] voice_active, note_on, note_off;
    logic [NV*KW-1:0] voice_key;
    logic steal, busy;

    int n_chk = 0;
    int n_pass = 0;

    // behavioural model state
    logic [NK-1:0] smp[$];
    bit m_act[NV];
    int m_key[NV];
    bit m_pend[NK];
    int m_steals;
    logic [NV-1:0] e_act, e_on, e_off;
    logic [NV*KW-1:0] e_key;
    logic e_steal, e_busy;

    voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW)) dut (
        .clk(clk),
        .rst(rst),
        .key_n(key_n),
        .voice_active(voice_active),
        .voice_key(voice_key),
        .note_on(note_on),
        .note_off(note_off),
        .steal(steal),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        smp.delete();
        repeat (3) smp.push_back('1);
        for (int v = 0; v < NV; v++) begin
            m_act[v] = 0;
            m_key[v] = 0;
        end
        for (int k = 0; k < NK; k++) m_pend[k] = 0;
        m_steals = 0;
        e_act = '0;
        e_key = '0;
        e_on = '0;
        e_off = '0;
        e_steal = 0;
        e_busy = 0;
    endtask

    // a key level sampled at edge n is acted on at edge n+2 (compared with the level from edge n-1)
    task automatic model_step(input logic [NK-1:0] now);
        bit prs[NK];
        bit rls[NK];
        int cand;
        int tgt;
        cand = -1;
        tgt = -1;
        for (int k = 0; k < NK; k++) begin
            prs[k] = smp[0][k] && !smp[1][k];
            rls[k] = !smp[0][k] && smp[1][k];
        end
        for (int k = 0; k < NK; k++)
            if (cand < 0 && m_pend[k] && !rls[k]) cand = k;
        e_on = '0;
        e_off = '0;
        e_steal = 0;
        if (cand >= 0) begin
            for (int v = 0; v < NV; v++)
                if (tgt < 0 && !m_act[v]) tgt = v;
            if (tgt < 0) begin
                tgt = m_steals % NV;
                m_steals++;
                e_steal = 1;
            end
        end
        for (int v = 0; v < NV; v++) begin
            if (v == tgt) begin
                m_act[v] = 1;
                m_key[v] = cand;
                e_on[v] = 1;
            end else if (m_act[v] && rls[m_key[v]]) begin
                m_act[v] = 0;
                e_off[v] = 1;
            end
        end
        e_busy = 0;
        for (int k = 0; k < NK; k++) begin
            if (prs[k]) m_pend[k] = 1;
            if (rls[k] || k == cand) m_pend[k] = 0;
            e_busy |= m_pend[k];
        end
        for (int v = 0; v < NV; v++) begin
            e_act[v] = m_act[v];
            e_key[v*KW +: KW] = KW'(m_key[v]);
        end
        smp.push_back(now);
        void'(smp.pop_front());
    endtask

    // step the model on every live edge and compare all outputs just after it
    always @(posedge clk) begin
        if (rst) model_reset();
        else begin
            model_step(key_n);
            #1;
            check("voice_active", 32'(voice_active), 32'(e_act));
            check("voice_key", 32'(voice_key), 32'(e_key));
            check("note_on", 32'(note_on), 32'(e_on));
            check("note_off", 32'(note_off), 32'(e_off));
            check("steal", 32'(steal), 32'(e_steal));
            check("busy", 32'(busy), 32'(e_busy));
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_active"}, 32'(voice_active), 32'd0);
        check({tag, "_key"}, 32'(voice_key), 32'd0);
        check({tag, "_on"}, 32'(note_on), 32'd0);
        check({tag, "_off"}, 32'(note_off), 32'd0);
        check({tag, "_steal"}, 32'(steal), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic hold(input logic [NK-1:0] k, input int n);
        key_n = k;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check_cleared("rst_mid");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [NK-1:0] nk;
        repeat (2) @(negedge clk);
        check_cleared("rst_init");
        rst = 1'b0;
        hold('1, 3);
        // single key 5 press and release
        hold(~8'h20, 8);
        hold('1, 6);
        // keys 2 and 6 on the same edge
        hold(~8'h44, 8);
        hold('1, 6);
        // fill all voices, then two steals
        hold(~8'h01, 1);
        hold(~8'h03, 1);
        hold(~8'h07, 1);
        hold(~8'h0F, 6);
        hold(~8'h8F, 6);
        hold(~8'h9F, 6);
        hold('1, 8);
        // two-cycle tap on key 3 behind three queued keys
        hold(~8'h0F, 2);
        hold(~8'h07, 8);
        hold('1, 8);
        // steal target released on the edge it is reassigned
        pulse_reset();
        hold(~8'h01, 1);
        hold(~8'h03, 1);
        hold(~8'h07, 1);
        hold(~8'h0F, 6);
        hold(~8'h8F, 1);
        hold(~8'h8E, 6);
        hold('1, 8);
        // reset with voices sounding and key 1 held through it
        hold(~8'h07, 6);
        hold(~8'h02, 1);
        pulse_reset();
        hold(~8'h02, 8);
        hold('1, 6);
        // random traffic with occasional resets
        nk = '1;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(5) == 0) nk[k] = ~nk[k];
            if ($urandom_range(499) == 0) pulse_reset();
            hold(nk, 1);
        end
        hold('1, 8);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
